ahb_rr_arbiter: RTL and testbench



---
 rtl/ahb_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_rr_arbiter.sv
// Round-robin bus arbiter for a 4-master AHB interconnect.
// Handles burst/lock-aware handover, SPLIT masking and data-phase master tracking.
module ahb_rr_arbiter #(
  parameter int NUM_MST = 4,
  parameter int DEF_MST = 0
) (
  input  logic               HCLK,
  input  logic               HRST,
  input  logic [NUM_MST-1:0] HBUSREQ,
  input  logic [NUM_MST-1:0] HLOCK,
  input  logic [1:0]         HTRANS,
  input  logic [2:0]         HBURST,
  input  logic               HREADY,
  input  logic [1:0]         HRESP,
  input  logic [15:0]        HSPLIT,
  output logic [NUM_MST-1:0] HGRANT,
  output logic [3:0]         HMASTER,
  output logic [3:0]         HMASTER_D,
  output logic               HMASTERLOCK,
  output logic               DefaultMst
);

  localparam int               IDX_W   = $clog2(NUM_MST);
  localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEF_MST);

  typedef enum logic [1:0] {TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ} trans_e;
  typedef enum logic [1:0] {RSP_OKAY, RSP_ERROR, RSP_RETRY, RSP_SPLIT} resp_e;
  typedef enum logic [2:0] {
    BR_SINGLE, BR_INCR, BR_WRAP4, BR_INCR4, BR_WRAP8, BR_INCR8, BR_WRAP16, BR_INCR16
  } burst_e;

  logic [NUM_MST-1:0] r_grant;
  logic [NUM_MST-1:0] r_split_mask;
  logic [IDX_W-1:0]   r_hmaster;
  logic [IDX_W-1:0]   r_hmaster_d;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_mlock;
  logic               r_default;
  logic [4:0]         r_beat_cnt;

  logic [NUM_MST-1:0] w_elig;
  logic [NUM_MST-1:0] w_grant_nxt;
  logic [NUM_MST-1:0] w_mask_nxt;
  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_found;
  logic               w_split_first;
  logic               w_lock_block;
  logic               w_rearb;
  logic               w_grant_upd;
  logic [4:0]         w_beat_nxt;
  logic               w_unused;

  assign w_unused = ^HSPLIT[15:NUM_MST];

  assign w_elig        = HBUSREQ & ~r_split_mask;
  assign w_split_first = !HREADY && (HRESP == RSP_SPLIT || HRESP == RSP_RETRY);
  // A split-masked owner cannot keep the bus locked: it is no longer driving it.
  assign w_lock_block  = (HLOCK[r_hmaster] | r_mlock) & ~r_split_mask[r_hmaster];
  assign w_rearb       = ((r_beat_cnt <= 5'd1) || (HTRANS == TR_IDLE) ||
                          (HBURST == BR_INCR) || w_split_first) && !w_lock_block;
  assign w_grant_upd   = w_rearb && (HREADY || w_split_first);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_winner = DEF_IDX;
    w_found  = 1'b0;
    w_cand   = r_rr_ptr;
    for (int k = 1; k <= NUM_MST; k++) begin
      w_cand = r_rr_ptr + IDX_W'(k);
      if (!w_found && w_elig[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
    w_grant_nxt           = '0;
    w_grant_nxt[w_winner] = 1'b1;
  end

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (r_grant[i]) w_grant_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_beat_nxt = r_beat_cnt;
    if (w_split_first) begin
      w_beat_nxt = 5'd0;
    end else if (HREADY) begin
      case (trans_e'(HTRANS))
        TR_IDLE:   w_beat_nxt = 5'd0;
        TR_BUSY:   w_beat_nxt = r_beat_cnt;
        TR_NONSEQ: begin
          case (burst_e'(HBURST))
            BR_SINGLE:            w_beat_nxt = 5'd1;
            BR_INCR:              w_beat_nxt = 5'd0;
            BR_WRAP4, BR_INCR4:   w_beat_nxt = 5'd4;
            BR_WRAP8, BR_INCR8:   w_beat_nxt = 5'd8;
            default:              w_beat_nxt = 5'd16;
          endcase
        end
        default:   w_beat_nxt = (r_beat_cnt == 5'd0) ? 5'd0 : r_beat_cnt - 5'd1;
      endcase
    end
  end

  // A SPLIT set on the same bit as an HSPLIT release wins, so it is applied last.
  always_comb begin
    w_mask_nxt = r_split_mask & ~HSPLIT[NUM_MST-1:0];
    if (w_split_first && HRESP == RSP_SPLIT) w_mask_nxt[r_hmaster_d] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      r_grant      <= NUM_MST'(1 << DEF_MST);
      r_hmaster    <= DEF_IDX;
      r_hmaster_d  <= DEF_IDX;
      r_rr_ptr     <= DEF_IDX;
      r_mlock      <= 1'b0;
      r_default    <= 1'b1;
      r_split_mask <= '0;
      r_beat_cnt   <= 5'd0;
    end else begin
      if (w_grant_upd) begin
        r_grant   <= w_grant_nxt;
        r_default <= !w_found;
        if (w_found) r_rr_ptr <= w_winner;
      end
      if (HREADY) begin
        r_hmaster   <= w_grant_idx;
        r_mlock     <= HLOCK[w_grant_idx];
        r_hmaster_d <= r_hmaster;
      end
      r_split_mask <= w_mask_nxt;
      r_beat_cnt   <= w_beat_nxt;
    end
  end

  assign HGRANT      = r_grant;
  assign HMASTER     = 4'(r_hmaster);
  assign HMASTER_D   = 4'(r_hmaster_d);
  assign HMASTERLOCK = r_mlock;
  assign DefaultMst  = r_default;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench for ahb_rr_arbiter: a cycle model feeds an expected-value
// queue that is drained and compared one cycle after each drive.
module tb_ahb_rr_arbiter;

  logic        HCLK = 1'b0;
  logic        HRST;
  logic [3:0]  HBUSREQ, HLOCK;
  logic [1:0]  HTRANS, HRESP;
  logic [2:0]  HBURST;
  logic        HREADY;
  logic [15:0] HSPLIT;
  logic [3:0]  HGRANT, HMASTER, HMASTER_D;
  logic        HMASTERLOCK, DefaultMst;

  ahb_rr_arbiter dut (
    .HCLK(HCLK), .HRST(HRST), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP), .HSPLIT(HSPLIT),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTER_D(HMASTER_D),
    .HMASTERLOCK(HMASTERLOCK), .DefaultMst(DefaultMst)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        rst;
    logic [3:0]  busreq;
    logic [3:0]  lock;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        ready;
    logic [1:0]  resp;
    logic [15:0] split;
  } stim_t;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] mst;
    logic [1:0] mst_d;
    logic       mlock;
    logic       dflt;
    logic [3:0] mask;
    logic [4:0] cnt;
    logic [1:0] ptr;
  } mdl_t;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR8 = 3'b101, INCR16 = 3'b111;

  mdl_t       m_state;
  mdl_t       sb_q[$];
  logic [3:0] grant_log[$];
  int         n_checks = 0;
  int         n_errors = 0;

  function automatic stim_t mk(input logic [3:0] busreq, input logic [3:0] lock,
                               input logic [1:0] trans, input logic [2:0] burst,
                               input logic ready, input logic [1:0] resp,
                               input logic [15:0] split, input logic rst);
    stim_t s;
    s.rst = rst; s.busreq = busreq; s.lock = lock; s.trans = trans;
    s.burst = burst; s.ready = ready; s.resp = resp; s.split = split;
    return s;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t s, input stim_t x);
    mdl_t       n;
    int         len[8];
    int         gidx, win, c;
    bit         any, sf, rearb;
    logic [3:0] elig;
    len = '{1, 0, 4, 4, 8, 8, 16, 16};
    if (x.rst) begin
      n.grant = 4'b0001; n.mst = 2'd0; n.mst_d = 2'd0; n.mlock = 1'b0;
      n.dflt = 1'b1; n.mask = 4'd0; n.cnt = 5'd0; n.ptr = 2'd0;
      return n;
    end
    n = s;
    gidx = 0;
    for (int i = 0; i < 4; i++) if (s.grant[i]) gidx = i;
    sf    = !x.ready && x.resp[1];
    rearb = (s.cnt < 2) || (x.trans == IDLE) || (x.burst == 3'b001) || sf;
    if ((x.lock[s.mst] || s.mlock) && !s.mask[s.mst]) rearb = 1'b0;
    elig = x.busreq & ~s.mask;
    win = 0;
    any = 1'b0;
    for (int off = 1; off <= 4; off++) begin
      c = (int'(s.ptr) + off) % 4;
      if (!any && elig[c]) begin win = c; any = 1'b1; end
    end
    if (rearb && (x.ready || sf)) begin
      n.grant = 4'(1 << win);
      n.dflt  = !any;
      if (any) n.ptr = 2'(win);
    end
    if (x.ready) begin
      n.mst   = 2'(gidx);
      n.mlock = x.lock[gidx];
      n.mst_d = s.mst;
    end
    if (sf) n.cnt = 5'd0;
    else if (x.ready) begin
      case (x.trans)
        2'b00:   n.cnt = 5'd0;
        2'b10:   n.cnt = 5'(len[x.burst]);
        2'b11:   n.cnt = (s.cnt == 5'd0) ? 5'd0 : s.cnt - 5'd1;
        default: n.cnt = s.cnt;
      endcase
    end
    n.mask = s.mask & ~x.split[3:0];
    if (sf && x.resp == 2'b11) n.mask[s.mst_d] = 1'b1;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input stim_t x);
    mdl_t e;
    HRST = x.rst; HBUSREQ = x.busreq; HLOCK = x.lock; HTRANS = x.trans;
    HBURST = x.burst; HREADY = x.ready; HRESP = x.resp; HSPLIT = x.split;
    m_state = mdl_next(m_state, x);
    sb_q.push_back(m_state);
    @(posedge HCLK);
    #1;
    e = sb_q.pop_front();
    check("HGRANT",      32'(HGRANT),           32'(e.grant));
    check("HMASTER",     32'(HMASTER),          32'(e.mst));
    check("HMASTER_D",   32'(HMASTER_D),        32'(e.mst_d));
    check("HMASTERLOCK", 32'(HMASTERLOCK),      32'(e.mlock));
    check("DefaultMst",  32'(DefaultMst),       32'(e.dflt));
    check("split_mask",  32'(dut.r_split_mask), 32'(e.mask));
    check("beat_cnt",    32'(dut.r_beat_cnt),   32'(e.cnt));
    grant_log.push_back(HGRANT);
  endtask

  task automatic do_reset();
    step(mk(4'd0, 4'd0, IDLE, SINGLE, 1'b1, 2'b00, 16'd0, 1'b1));
  endtask

  task automatic idle(input logic [3:0] busreq, input int n);
    for (int i = 0; i < n; i++) step(mk(busreq, 4'd0, IDLE, SINGLE, 1'b1, 2'b00, 16'd0, 1'b0));
  endtask

  initial begin
    logic [3:0] rr_exp[6];
    stim_t      r;
    rr_exp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
    m_state = '0;

    // Reset state with no requests.
    do_reset();
    do_reset();
    check("rst_grant", 32'(HGRANT), 32'h1);
    check("rst_hmaster", 32'(HMASTER), 32'h0);
    check("rst_default", 32'(DefaultMst), 32'h1);
    check("rst_mlock", 32'(HMASTERLOCK), 32'h0);

    // Masters 1..3 issue back-to-back SINGLE transfers.
    grant_log.delete();
    for (int i = 0; i < 6; i++)
      step(mk(4'b1110, 4'd0, NONSEQ, SINGLE, 1'b1, 2'b00, 16'd0, 1'b0));
    for (int i = 0; i < 6; i++) check("rr_order", 32'(grant_log[i]), 32'(rr_exp[i]));

    // M1 INCR8 burst, M2 requests from beat 2.
    do_reset();
    idle(4'b0010, 2);
    step(mk(4'b0010, 4'd0, NONSEQ, INCR8, 1'b1, 2'b00, 16'd0, 1'b0));
    for (int i = 0; i < 7; i++) begin
      step(mk(4'b0110, 4'd0, SEQ, INCR8, 1'b1, 2'b00, 16'd0, 1'b0));
      check("incr8_hold", 32'(HGRANT), 32'h2);
    end
    idle(4'b0110, 1);
    check("incr8_handover", 32'(HGRANT), 32'h4);
    idle(4'b0110, 1);
    check("incr8_hmaster", 32'(HMASTER), 32'h2);

    // M0 locked SINGLE transfers while M3 requests.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(mk(4'b1001, 4'b0001, NONSEQ, SINGLE, 1'b1, 2'b00, 16'd0, 1'b0));
    check("lock_mlock", 32'(HMASTERLOCK), 32'h1);
    check("lock_grant", 32'(HGRANT), 32'h1);
    idle(4'b1000, 1);
    check("lock_release_hold", 32'(HGRANT), 32'h1);
    idle(4'b1000, 1);
    check("lock_release_grant", 32'(HGRANT), 32'h8);

    // M2 gets SPLIT (with a coincident HSPLIT[2]) while M1 requests.
    do_reset();
    idle(4'b0100, 2);
    step(mk(4'b0100, 4'd0, NONSEQ, SINGLE, 1'b1, 2'b00, 16'd0, 1'b0));
    step(mk(4'b0110, 4'd0, IDLE, SINGLE, 1'b0, 2'b11, 16'h0004, 1'b0));
    check("split_grant", 32'(HGRANT), 32'h2);
    check("split_mask_set", 32'(dut.r_split_mask), 32'h4);
    check("split_hmaster_frozen", 32'(HMASTER), 32'h2);
    step(mk(4'b0110, 4'd0, IDLE, SINGLE, 1'b1, 2'b11, 16'd0, 1'b0));
    for (int i = 0; i < 2; i++)
      step(mk(4'b0110, 4'd0, IDLE, SINGLE, 1'b1, 2'b00, 16'hFFF0, 1'b0));
    check("split_masked_m2", 32'(HGRANT), 32'h2);
    step(mk(4'b0110, 4'd0, IDLE, SINGLE, 1'b1, 2'b00, 16'h0004, 1'b0));
    idle(4'b0110, 1);
    check("split_release_grant", 32'(HGRANT), 32'h4);

    // Reset in the middle of an INCR16 burst with HREADY low.
    do_reset();
    idle(4'b0010, 2);
    step(mk(4'b0010, 4'd0, NONSEQ, INCR16, 1'b1, 2'b00, 16'd0, 1'b0));
    for (int i = 0; i < 3; i++)
      step(mk(4'b0010, 4'd0, SEQ, INCR16, 1'b1, 2'b00, 16'd0, 1'b0));
    step(mk(4'b0010, 4'd0, SEQ, INCR16, 1'b0, 2'b00, 16'd0, 1'b1));
    check("midrst_grant", 32'(HGRANT), 32'h1);
    check("midrst_hmaster_d", 32'(HMASTER_D), 32'h0);
    check("midrst_default", 32'(DefaultMst), 32'h1);
    check("midrst_beat_cnt", 32'(dut.r_beat_cnt), 32'h0);

    // Constrained-random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r.rst    = ($urandom_range(0, 63) == 0);
      r.busreq = 4'($urandom);
      r.lock   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
      r.trans  = 2'($urandom);
      r.burst  = 3'($urandom);
      r.ready  = ($urandom_range(0, 4) != 0);
      r.resp   = 2'($urandom);
      r.split  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'd0;
      step(r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
